decod_seq: RTL and testbench

//  Upstream sequencer for the 4-to-16 one-hot decoder (inputs a,b,c,d select, e enable).

---
 rtl/decod_seq.sv | 133 +++++++++++++
 tb/tb_decod_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/decod_seq.sv
// Request queue and pulse sequencer feeding a 4-to-16 one-hot decoder.
// Each queued {code, hold} is replayed as select setup, then an enable pulse of hold+1 cycles.
//   state | meaning
//   IDLE  | enable low, pops the head entry when the queue is non-empty
//   SETUP | select lines driven, enable still low for one cycle
//   DRIVE | enable high, hold counter runs down to zero
//   GAP   | enable low for GAP_CYCLES before the next pop
module decod_seq #(
    parameter int DEPTH      = 4,
    parameter int HOLD_W     = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       req_valid,
    input  logic [3:0]                 req_code,
    input  logic [HOLD_W-1:0]          req_hold,
    output logic                       req_ready,
    output logic                       dec_a,
    output logic                       dec_b,
    output logic                       dec_c,
    output logic                       dec_d,
    output logic                       dec_e,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam int GAP_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [3:0] GAP_LOAD = 4'(GAP_LOAD_I);

    typedef enum logic [1:0] {IDLE, SETUP, DRIVE, GAP} state_t;

    state_t              state;
    logic [HOLD_W-1:0]   cnt;
    logic [3:0]          gap_cnt;
    logic [3:0]          code_mem [DEPTH];
    logic [HOLD_W-1:0]   hold_mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic                push;
    logic                pop;

    // Readiness is judged on the registered level only, so a full queue refuses even while popping.
    assign req_ready = (level != FULL_LEVEL) && !flush;
    assign busy      = (state != IDLE) || (level != '0);
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (level != '0) && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            code_mem[wr_ptr] <= req_code;
            hold_mem[wr_ptr] <= req_hold;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Select lines only change on the pop edge, so they are stable for the whole enable window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dec_a   <= 1'b0;
            dec_b   <= 1'b0;
            dec_c   <= 1'b0;
            dec_d   <= 1'b0;
            dec_e   <= 1'b0;
            cnt     <= '0;
            gap_cnt <= '0;
        end else if (flush) begin
            state <= IDLE;
            dec_e <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dec_e <= 1'b0;
                    if (level != '0) begin
                        {dec_a, dec_b, dec_c, dec_d} <= code_mem[rd_ptr];
                        cnt   <= hold_mem[rd_ptr];
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    dec_e <= 1'b1;
                    state <= DRIVE;
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        dec_e <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            gap_cnt <= GAP_LOAD;
                            state   <= GAP;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - HOLD_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decod_seq.sv
// Scoreboard bench for decod_seq: each accepted request gets a scheduled pop edge from
// the timing rules; a monitor checks enable, select, level and busy every cycle.
module tb_decod_seq;
    localparam int DEPTH  = 4;
    localparam int HOLD_W = 4;
    localparam int GAP    = 1;

    logic              clk = 1'b0;
    logic              rst, flush, req_valid;
    logic [3:0]        req_code;
    logic [HOLD_W-1:0] req_hold;
    logic              req_ready, dec_a, dec_b, dec_c, dec_d, dec_e, busy;
    logic [2:0]        level;

    decod_seq #(.DEPTH(DEPTH), .HOLD_W(HOLD_W), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid),
        .req_code(req_code), .req_hold(req_hold), .req_ready(req_ready),
        .dec_a(dec_a), .dec_b(dec_b), .dec_c(dec_c), .dec_d(dec_d), .dec_e(dec_e),
        .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int code;
        int hold;
        int pop_edge;
    } req_t;

    req_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   free_edge = 0;
    int   clr_edge = -1;
    bit   clr_rst = 1'b0;
    bit   last_acc = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int pending_from(int k);
        int c = 0;
        foreach (sb[i]) if (sb[i].pop_edge >= k) c++;
        return c;
    endfunction

    // Drive one clock's inputs; the request (if accepted) is scheduled for the edge it will pop on.
    task automatic step(bit v, int code, int hold, bit fl, bit rs);
        int k;
        bit exp_rdy;
        int pe;
        @(negedge clk);
        k = cyc + 1;
        rst       = rs;
        flush     = fl;
        req_valid = v;
        req_code  = code[3:0];
        req_hold  = hold[HOLD_W-1:0];
        #1;
        exp_rdy = !fl && (pending_from(k) < DEPTH);
        chk("req_ready", req_ready, exp_rdy);
        last_acc = 1'b0;
        if (rs || fl) begin
            sb.delete();
            free_edge = 0;
            clr_edge  = k;
            clr_rst   = rs;
        end else if (v && exp_rdy) begin
            pe = (k + 1 > free_edge) ? k + 1 : free_edge;
            sb.push_back('{code, hold, pe});
            free_edge = pe + hold + 3 + GAP;
            last_acc  = 1'b1;
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic push_wait(int code, int hold);
        for (int t = 0; t < 60; t++) begin
            step(1'b1, code, hold, 1'b0, 1'b0);
            if (last_acc) return;
        end
        chk("push_accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin : monitor
        logic       prev_e;
        int         busy_until;
        int         cur_end;
        bit         cur_active;
        logic [3:0] exp_code;
        req_t       e;
        int         n;
        int         lvl;
        bit         rose;
        bit         exp_e;
        prev_e = 1'b0;
        busy_until = 0;
        cur_end = 0;
        cur_active = 1'b0;
        exp_code = 4'd0;
        forever begin
            @(posedge clk);
            #1;
            n = cyc;
            if (n == clr_edge) begin
                if (cur_active && cur_end > n) cur_end = n;
                busy_until = n;
                if (clr_rst) exp_code = 4'd0;
            end
            foreach (sb[i]) begin
                if (sb[i].pop_edge == n) begin
                    exp_code   = sb[i].code[3:0];
                    busy_until = n + sb[i].hold + 2 + GAP;
                end
            end
            rose = (dec_e === 1'b1) && (prev_e === 1'b0);
            if (sb.size() > 0 && (rose || sb[0].pop_edge + 1 <= n)) begin
                e = sb.pop_front();
                chk("pulse_start_edge", rose ? n : 0, e.pop_edge + 1);
                cur_active = 1'b1;
                cur_end    = e.pop_edge + e.hold + 2;
            end else if (rose) begin
                chk("spurious_pulse", 32'd1, 32'd0);
            end
            exp_e = cur_active && (n < cur_end);
            chk("dec_e", dec_e, exp_e);
            chk("dec_code", {dec_a, dec_b, dec_c, dec_d}, exp_code);
            lvl = 0;
            foreach (sb[i]) if (sb[i].pop_edge > n) lvl++;
            chk("level", level, lvl);
            chk("busy", busy, (lvl > 0) || (n < busy_until));
            prev_e = dec_e;
        end
    end

    initial begin : driver
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_code  = 4'd0;
        req_hold  = '0;
        clr_edge  = 1;
        clr_rst   = 1'b1;
        step(1'b0, 0, 0, 1'b0, 1'b1);

        // single short pulse on code F
        step(1'b1, 15, 0, 1'b0, 1'b0);
        idle(8);
        // four-cycle pulse on code 5
        step(1'b1, 5, 3, 1'b0, 1'b0);
        idle(10);
        // fill the queue behind a long pulse, then hold a fifth request until it fits
        step(1'b1, 9, 7, 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < 4; i++) step(1'b1, i, 0, 1'b0, 1'b0);
        push_wait(10, 1);
        idle(40);
        // flush mid-DRIVE with two entries waiting
        step(1'b1, 6, 7, 1'b0, 1'b0);
        step(1'b1, 1, 0, 1'b0, 1'b0);
        step(1'b1, 2, 0, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 0, 0, 1'b1, 1'b0);
        idle(6);
        // reset during GAP with three entries waiting, then a fresh request
        step(1'b1, 3, 1, 1'b0, 1'b0);
        step(1'b1, 7, 0, 1'b0, 1'b0);
        step(1'b1, 8, 0, 1'b0, 1'b0);
        step(1'b1, 11, 0, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b1, 12, 2, 1'b0, 1'b0);
        idle(8);

        for (int r = 0; r < 400; r++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)), ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 99) == 0));
        end

        for (int t = 0; t < 300 && sb.size() > 0; t++) idle(1);
        if (sb.size() > 0) chk("drain_timeout", sb.size(), 32'd0);
        idle(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
